// File: rtl/ecc_pkg.sv
// Shared types and widths for the ECC correction / scrub path.
`ifndef ECC_WORD_SIZE
`define ECC_WORD_SIZE 32
`endif
`ifndef ECC_RED_N_BITS
`define ECC_RED_N_BITS 12
`endif

package ecc_pkg;

    localparam int ECC_WORD_W = `ECC_WORD_SIZE;
    localparam int ECC_RED_W  = `ECC_RED_N_BITS;
    localparam int ECC_ADDR_W = 16;
    localparam int ECC_CNT_W  = 16;

    // Statistics counter slots
    localparam int ECC_N_CNT     = 2;
    localparam int ECC_CNT_CORR  = 0;
    localparam int ECC_CNT_UNC   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        DELIVER = 2'd2
    } ecc_scrub_state_t;

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter; a clear always beats an increment in the same cycle.
module ecc_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Next count: clear first, otherwise increment unless already all-ones
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/ecc_corr_scrub.sv
// Read-path correction stage: feeds the BCH decoder, applies its mask,
// delivers corrected words, optionally writes them back re-encoded, and
// keeps saturating corrected / uncorrectable statistics.
module ecc_corr_scrub
    import ecc_pkg::*;
#(
    parameter int WORD_W = ECC_WORD_W,
    parameter int RED_W  = ECC_RED_W,
    parameter int ADDR_W = ECC_ADDR_W,
    parameter int CNT_W  = ECC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    // raw read word
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    input  logic [RED_W-1:0]  rd_ecc,
    input  logic              scrub_en,
    // decoder
    output logic [WORD_W-1:0] dec_read_bits,
    output logic [RED_W-1:0]  dec_read_ecc,
    input  logic [WORD_W-1:0] dec_msk,
    input  logic              dec_err_det,
    // encoder
    output logic [WORD_W-1:0] enc_write_bits,
    input  logic [RED_W-1:0]  enc_write_ecc,
    // corrected output
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_uncorr,
    // write-back
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WORD_W-1:0] wb_data,
    output logic [RED_W-1:0]  wb_ecc,
    // statistics
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    ecc_scrub_state_t state_reg, state_next;

    // Captured read word; stays put from accept until the word is retired
    logic [ADDR_W-1:0] addr_reg;
    logic [WORD_W-1:0] data_reg;
    logic [RED_W-1:0]  ecc_reg;
    logic              scrub_reg;

    // Decode results captured at the end of DECODE
    logic [WORD_W-1:0] corr_reg;
    logic              unc_reg;
    logic [RED_W-1:0]  wb_ecc_reg;

    // Outstanding handshakes while in DELIVER
    logic              out_pend_reg, out_pend_next;
    logic              wb_pend_reg, wb_pend_next;

    logic [WORD_W-1:0] corr_comb;
    logic              fix_comb;
    logic              unc_comb;
    logic              accept;
    logic              sample;

    logic [ECC_N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]     cnt_val [ECC_N_CNT];

    // Correction arithmetic. A non-zero mask is authoritative even when the
    // decoder does not flag an error; "uncorrectable" means detected but no fix.
    assign corr_comb = data_reg ^ dec_msk;
    assign fix_comb  = |dec_msk;
    assign unc_comb  = dec_err_det & ~fix_comb;

    // Decoder/encoder feeds come straight from the captured word
    assign dec_read_bits  = data_reg;
    assign dec_read_ecc   = ecc_reg;
    assign enc_write_bits = corr_comb;

    // Next-state and handshake bookkeeping
    always_comb begin
        state_next    = state_reg;
        rd_ready      = 1'b0;
        accept        = 1'b0;
        sample        = 1'b0;
        out_pend_next = out_pend_reg;
        wb_pend_next  = wb_pend_reg;
        case (state_reg)
            IDLE: begin
                rd_ready = 1'b1;
                if (rd_valid) begin
                    accept     = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                sample        = 1'b1;
                out_pend_next = 1'b1;
                wb_pend_next  = fix_comb & scrub_reg & ~unc_comb;
                state_next    = DELIVER;
            end
            DELIVER: begin
                if (out_pend_reg && out_ready) begin
                    out_pend_next = 1'b0;
                end
                if (wb_pend_reg && wb_ready) begin
                    wb_pend_next = 1'b0;
                end
                if (!out_pend_next && !wb_pend_next) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                out_pend_next = 1'b0;
                wb_pend_next  = 1'b0;
            end
        endcase
    end

    // State and pending-handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            out_pend_reg <= 1'b0;
            wb_pend_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            out_pend_reg <= out_pend_next;
            wb_pend_reg  <= wb_pend_next;
        end
    end

    // Capture the read word on accept and the decode result at end of DECODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= '0;
            data_reg   <= '0;
            ecc_reg    <= '0;
            scrub_reg  <= 1'b0;
            corr_reg   <= '0;
            unc_reg    <= 1'b0;
            wb_ecc_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg  <= rd_addr;
                data_reg  <= rd_data;
                ecc_reg   <= rd_ecc;
                scrub_reg <= scrub_en;
            end
            if (sample) begin
                corr_reg   <= corr_comb;
                unc_reg    <= unc_comb;
                wb_ecc_reg <= enc_write_ecc;
            end
        end
    end

    // Output side: each channel's valid is just its pending flag, so data
    // stays frozen in the capture registers until that handshake completes.
    assign out_valid  = out_pend_reg;
    assign out_data   = unc_reg ? data_reg : corr_reg;
    assign out_uncorr = unc_reg;
    assign wb_valid   = wb_pend_reg;
    assign wb_addr    = addr_reg;
    assign wb_data    = corr_reg;
    assign wb_ecc     = wb_ecc_reg;

    // Counters bump at the edge that enters DELIVER, once per word
    assign cnt_inc[ECC_CNT_CORR] = sample & fix_comb & ~unc_comb;
    assign cnt_inc[ECC_CNT_UNC]  = sample & unc_comb;

    for (genvar gi = 0; gi < ECC_N_CNT; gi++) begin : g_cnt
        ecc_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr_stats),
            .inc (cnt_inc[gi]),
            .cnt (cnt_val[gi])
        );
    end

    assign corr_cnt   = cnt_val[ECC_CNT_CORR];
    assign uncorr_cnt = cnt_val[ECC_CNT_UNC];

endmodule

// File: tb/tb_ecc_corr_scrub.sv
// Self-checking bench for ecc_corr_scrub: directed table, reset-in-flight
// sequence and randomized words against a behavioural model.
module tb_ecc_corr_scrub;

    localparam int WW = 32;
    localparam int RW = 12;
    localparam int AW = 16;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] rd_data;
    logic [RW-1:0] rd_ecc;
    logic          scrub_en;
    logic [WW-1:0] dec_read_bits;
    logic [RW-1:0] dec_read_ecc;
    logic [WW-1:0] dec_msk;
    logic          dec_err_det;
    logic [WW-1:0] enc_write_bits;
    logic [RW-1:0] enc_write_ecc;
    logic          out_valid, out_ready, out_uncorr;
    logic [WW-1:0] out_data;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [WW-1:0] wb_data;
    logic [RW-1:0] wb_ecc;
    logic          clr_stats;
    logic [CW-1:0] corr_cnt, uncorr_cnt;

    int checks = 0;
    int failures = 0;
    int m_corr = 0;
    int m_unc = 0;

    always #5 clk = ~clk;

    // Stand-in encoder: any fixed function of the data will do
    function automatic logic [RW-1:0] enc_f(input logic [WW-1:0] b);
        return b[11:0] ^ b[23:12] ^ {4'h0, b[31:24]} ^ 12'h5A3;
    endfunction

    assign enc_write_ecc = enc_f(enc_write_bits);

    ecc_corr_scrub #(
        .WORD_W (WW), .RED_W (RW), .ADDR_W (AW), .CNT_W (CW)
    ) dut (
        .clk (clk), .rst (rst),
        .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_addr (rd_addr),
        .rd_data (rd_data), .rd_ecc (rd_ecc), .scrub_en (scrub_en),
        .dec_read_bits (dec_read_bits), .dec_read_ecc (dec_read_ecc),
        .dec_msk (dec_msk), .dec_err_det (dec_err_det),
        .enc_write_bits (enc_write_bits), .enc_write_ecc (enc_write_ecc),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_uncorr (out_uncorr),
        .wb_valid (wb_valid), .wb_ready (wb_ready), .wb_addr (wb_addr),
        .wb_data (wb_data), .wb_ecc (wb_ecc),
        .clr_stats (clr_stats), .corr_cnt (corr_cnt), .uncorr_cnt (uncorr_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic [RW-1:0] ecc;
        logic [WW-1:0] msk;
        logic          err;
        logic          scrub;
        int            od;
        int            wd;
        logic          clr;
        logic [WW-1:0] x_data;
        logic          x_unc;
        logic          x_wb;
        int            x_corr;
        int            x_ucnt;
    } vec_t;

    vec_t tbl [7];

    // One full word: present in IDLE, check DECODE, then walk DELIVER with
    // out_ready/wb_ready delayed by od/wd cycles. Entered and left at a negedge.
    task automatic run_txn(input string tag, input vec_t v);
        logic op, wp;
        int   k;
        chk({tag, "_idle_rd_ready"}, rd_ready, 1);
        rd_valid    = 1'b1;
        rd_addr     = v.addr;
        rd_data     = v.data;
        rd_ecc      = v.ecc;
        scrub_en    = v.scrub;
        dec_msk     = v.msk;
        dec_err_det = v.err;
        out_ready   = 1'b0;
        wb_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Changing inputs after accept must not affect the in-flight word
        rd_valid = 1'b0;
        rd_data  = $urandom;
        rd_addr  = AW'($urandom);
        scrub_en = ~v.scrub;
        chk({tag, "_dec_rd_ready"}, rd_ready, 0);
        chk({tag, "_dec_out_valid"}, out_valid, 0);
        chk({tag, "_dec_wb_valid"}, wb_valid, 0);
        chk({tag, "_dec_read_bits"}, dec_read_bits, v.data);
        chk({tag, "_dec_read_ecc"}, dec_read_ecc, v.ecc);
        chk({tag, "_enc_write_bits"}, enc_write_bits, v.data ^ v.msk);
        clr_stats = v.clr;
        @(posedge clk);
        @(negedge clk);
        clr_stats = 1'b0;
        op = 1'b1;
        wp = v.x_wb;
        k  = 0;
        while ((op || wp) && k < 64) begin
            chk({tag, "_out_valid"}, out_valid, op);
            chk({tag, "_wb_valid"}, wb_valid, wp);
            chk({tag, "_busy_rd_ready"}, rd_ready, 0);
            chk({tag, "_corr_cnt"}, corr_cnt, v.x_corr);
            chk({tag, "_uncorr_cnt"}, uncorr_cnt, v.x_ucnt);
            if (op) begin
                chk({tag, "_out_data"}, out_data, v.x_data);
                chk({tag, "_out_uncorr"}, out_uncorr, v.x_unc);
            end
            if (wp) begin
                chk({tag, "_wb_addr"}, wb_addr, v.addr);
                chk({tag, "_wb_data"}, wb_data, v.x_data);
                chk({tag, "_wb_ecc"}, wb_ecc, enc_f(v.x_data));
            end
            out_ready = (k >= v.od);
            wb_ready  = (k >= v.wd);
            @(posedge clk);
            @(negedge clk);
            if (op && out_ready) op = 1'b0;
            if (wp && wb_ready)  wp = 1'b0;
            k++;
        end
        chk({tag, "_deliver_timeout"}, {op, wp}, 0);
        out_ready = 1'b0;
        wb_ready  = 1'b0;
        chk({tag, "_end_out_valid"}, out_valid, 0);
        chk({tag, "_end_wb_valid"}, wb_valid, 0);
        chk({tag, "_end_rd_ready"}, rd_ready, 1);
        $display("txn %s addr=%h data=%h msk=%h err=%b -> out=%h unc=%b wb=%b corr_cnt=%0d uncorr_cnt=%0d",
                 tag, v.addr, v.data, v.msk, v.err, v.x_data, v.x_unc, v.x_wb, corr_cnt, uncorr_cnt);
    endtask

    // Behavioural reference: fill in expectations for a word from the rules
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic fix, unc;
        r = v;
        fix = (v.msk != 0);
        unc = v.err && !fix;
        r.x_data = unc ? v.data : (v.data ^ v.msk);
        r.x_unc  = unc;
        r.x_wb   = fix && v.scrub && !unc;
        if (v.clr) begin
            m_corr = 0;
            m_unc  = 0;
        end else begin
            if (fix && !unc && m_corr < CMAX) m_corr++;
            if (unc && m_unc < CMAX) m_unc++;
        end
        r.x_corr = m_corr;
        r.x_ucnt = m_unc;
        return r;
    endfunction

    initial begin
        vec_t v;
        logic [WW-1:0] m;
        rst = 1'b1;
        rd_valid = 0; rd_addr = 0; rd_data = 0; rd_ecc = 0; scrub_en = 0;
        dec_msk = 0; dec_err_det = 0; out_ready = 0; wb_ready = 0; clr_stats = 0;

        //            addr     data          ecc      msk           err scr od wd clr  x_data        unc wb  corr ucnt
        tbl[0] = '{16'h0010, 32'h123456A5, 12'h111, 32'h00000000, 0, 1, 0, 0, 0, 32'h123456A5, 0, 0, 0, 0};
        tbl[1] = '{16'h0020, 32'hDEADBEE0, 12'h222, 32'h00000004, 1, 1, 0, 0, 0, 32'hDEADBEE4, 0, 1, 1, 0};
        tbl[2] = '{16'h0030, 32'h0F0F0F0F, 12'h333, 32'h00000000, 1, 1, 0, 0, 0, 32'h0F0F0F0F, 1, 0, 1, 1};
        tbl[3] = '{16'h0040, 32'h00000001, 12'h444, 32'h00000100, 1, 1, 5, 0, 0, 32'h00000101, 0, 1, 2, 1};
        tbl[4] = '{16'h0050, 32'hFFFF0000, 12'h555, 32'h80000000, 0, 0, 0, 0, 0, 32'h7FFF0000, 0, 0, 3, 1};
        tbl[5] = '{16'h0060, 32'hAAAA5555, 12'h666, 32'h00000001, 1, 1, 0, 2, 0, 32'hAAAA5554, 0, 1, 3, 1};
        tbl[6] = '{16'h0070, 32'h00000005, 12'h777, 32'h00000002, 1, 0, 0, 0, 1, 32'h00000007, 0, 0, 0, 0};

        // Reset state
        @(negedge clk);
        chk("rst_rd_ready", rd_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        chk("rst_uncorr_cnt", uncorr_cnt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wb_addr", wb_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("tbl%0d", i), tbl[i]);
        end

        // Reset while both valids are high in DELIVER
        rd_valid = 1; rd_addr = 16'h0ABC; rd_data = 32'h00FF00FF; rd_ecc = 12'h0AB;
        scrub_en = 1; dec_msk = 32'h00010000; dec_err_det = 1;
        @(posedge clk); @(negedge clk);
        rd_valid = 0;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_wb_valid", wb_valid, 1);
        chk("pre_rst_corr_cnt", corr_cnt, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_rd_ready", rd_ready, 1);
        chk("mid_rst_corr_cnt", corr_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_corr = 0;
        m_unc  = 0;
        v = '{16'h0100, 32'hCAFEF00D, 12'h0CD, 32'h00000000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        run_txn("post_rst", model(v));

        // Randomized words against the model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = WW'(1) << $urandom_range(0, WW - 1);
                2: m = (WW'(1) << $urandom_range(0, WW - 1)) | (WW'(1) << $urandom_range(0, WW - 1));
                default: m = $urandom;
            endcase
            v.addr  = AW'($urandom);
            v.data  = $urandom;
            v.ecc   = RW'($urandom);
            v.msk   = m;
            v.err   = 1'($urandom);
            v.scrub = 1'($urandom);
            v.od    = $urandom_range(0, 3);
            v.wd    = $urandom_range(0, 3);
            v.clr   = ($urandom_range(0, 7) == 0);
            run_txn($sformatf("rnd%0d", i), model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
